// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port data RAM between two requesters.
//   Port 0 is the core load/store path, port 1 the host/debug loader.
//   Round-robin arbitration with an optional locked burst of up to
//   MAX_BURST consecutive beats for the current owner.
//
// Optional build macro: RAM_ARBITER_STATS_EN
//   Adds the stats_clr input and the saturating counters gnt_cnt0,
//   gnt_cnt1 and conflict_cnt (CNT_W bits each).
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   reqN/weN/lockN      request, write enable, burst lock per port
//   addrN/wdataN        access address / write data per port
//   gntN                combinational grant (beat = reqN & gntN)
//   rdataN/rvalidN      registered read data and its one-cycle strobe
//   ram_addr/ram_din    address / write data driven to the RAM
//   ram_we              RAM write enable
//   ram_dout            combinational RAM read data
module ram_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
`ifdef RAM_ARBITER_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    // Parameter sanity check at elaboration time.
    if (MAX_BURST < 1 || MAX_BURST > 16 || CNT_W < 1) begin : g_bad_param
        $error("ram_arbiter: MAX_BURST must be 1..16 and CNT_W >= 1");
    end

    // The hold rule applies while beat_cnt is below this limit; with
    // MAX_BURST == 1 the limit is 0, so locking never holds the grant.
    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_BURST - 1);

    logic       owner;
    logic       owner_valid;
    logic       last_winner;
    logic [3:0] beat_cnt;

    logic [1:0] req;
    logic [1:0] lock;
    logic       hold;
    logic       beat0;
    logic       beat1;
    logic       beat_port;

    assign req  = {req1, req0};
    assign lock = {lock1, lock0};

    // Grant selection in priority order: burst hold, tie, single request.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        hold = owner_valid && req[owner] && lock[owner] && (beat_cnt < HOLD_LIMIT);
        if (hold) begin
            if (owner) gnt1 = 1'b1;
            else       gnt0 = 1'b1;
        end else if (req0 && req1) begin
            if (last_winner) gnt0 = 1'b1;
            else             gnt1 = 1'b1;
        end else if (req0) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end
    end

    // RAM drive follows the granted port; port 0 values when idle.
    always_comb begin
        ram_addr = addr0;
        ram_din  = wdata0;
        ram_we   = 1'b0;
        if (gnt1) begin
            ram_addr = addr1;
            ram_din  = wdata1;
            ram_we   = we1 & req1;
        end else if (gnt0) begin
            ram_we   = we0 & req0;
        end
    end

    assign beat0     = req0 & gnt0;
    assign beat1     = req1 & gnt1;
    assign beat_port = beat1;

    // Ownership / burst tracking. beat_cnt saturates so that repeated
    // uncontested locked beats cannot wrap back into a fresh hold window.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner       <= 1'b0;
            owner_valid <= 1'b0;
            last_winner <= 1'b1;
            beat_cnt    <= '0;
        end else if (beat0 || beat1) begin
            last_winner <= beat_port;
            owner       <= beat_port;
            owner_valid <= 1'b1;
            if ((beat_port == owner) && owner_valid && lock[beat_port]) begin
                if (beat_cnt != 4'hF) beat_cnt <= beat_cnt + 4'd1;
            end else begin
                beat_cnt <= '0;
            end
        end else begin
            owner_valid <= 1'b0;
            beat_cnt    <= '0;
        end
    end

    // Read return path: data captured at the beat edge, strobe for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= beat0 & ~we0;
            rvalid1 <= beat1 & ~we1;
            if (beat0 && !we0) rdata0 <= ram_dout;
            if (beat1 && !we1) rdata1 <= ram_dout;
        end
    end

`ifdef RAM_ARBITER_STATS_EN
    // Saturating statistics counters; clear takes precedence over counting.
    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            gnt_cnt0     <= '0;
            gnt_cnt1     <= '0;
            conflict_cnt <= '0;
        end else begin
            if (beat0 && (gnt_cnt0 != '1)) gnt_cnt0 <= gnt_cnt0 + 1'b1;
            if (beat1 && (gnt_cnt1 != '1)) gnt_cnt1 <= gnt_cnt1 + 1'b1;
            if (req0 && req1 && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter (MAX_BURST=4, CNT_W=2).
// A small behavioural RAM answers ram_addr combinationally and writes
// on the rising edge. Inputs change on the falling edge; outputs are
// sampled 1 time unit later.
module tb_ram_arbiter;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 2;

    logic          clk;
    logic          reset;
    logic          req0, we0, lock0, req1, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, ram_we;
    logic [DW-1:0] rdata0, rdata1, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;
`ifdef RAM_ARBITER_STATS_EN
    logic             stats_clr;
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

    logic [DW-1:0] mem [0:255];

    int checks = 0;
    int fails  = 0;

    ram_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
`ifdef RAM_ARBITER_STATS_EN
        ,
        .stats_clr(stats_clr), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
        .conflict_cnt(conflict_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign ram_dout = mem[ram_addr[7:0]];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_din;
    end

    task automatic drive(input logic r0, input logic w0, input logic l0,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1, input logic l1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
`ifdef RAM_ARBITER_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (gnt0 !== 1'b0)    begin fails++; $display("FAIL reset_gnt0: got %b expected 0", gnt0); end
        checks++; if (gnt1 !== 1'b0)    begin fails++; $display("FAIL reset_gnt1: got %b expected 0", gnt1); end
        checks++; if (ram_we !== 1'b0)  begin fails++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
        checks++; if (rvalid0 !== 1'b0) begin fails++; $display("FAIL reset_rvalid0: got %b expected 0", rvalid0); end
        checks++; if (rvalid1 !== 1'b0) begin fails++; $display("FAIL reset_rvalid1: got %b expected 0", rvalid1); end
        checks++; if (rdata0 !== '0)    begin fails++; $display("FAIL reset_rdata0: got %h expected 0", rdata0); end
        checks++; if (rdata1 !== '0)    begin fails++; $display("FAIL reset_rdata1: got %h expected 0", rdata1); end
    endtask

    task automatic test_write_read();
        // port 0 writes 0xAA to address 5
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 5, 'hAA, 1'b0, 1'b0, 1'b0, 0, 0); #1;
        checks++; if (gnt0 !== 1'b1)   begin fails++; $display("FAIL wr_gnt0: got %b expected 1", gnt0); end
        checks++; if (gnt1 !== 1'b0)   begin fails++; $display("FAIL wr_gnt1: got %b expected 0", gnt1); end
        checks++; if (ram_we !== 1'b1) begin fails++; $display("FAIL wr_ram_we: got %b expected 1", ram_we); end
        checks++; if (ram_addr !== 5)  begin fails++; $display("FAIL wr_ram_addr: got %h expected 5", ram_addr); end
        checks++; if (ram_din !== 'hAA) begin fails++; $display("FAIL wr_ram_din: got %h expected aa", ram_din); end
        // port 0 reads address 5
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0, 1'b0, 0, 0); #1;
        checks++; if (gnt0 !== 1'b1)    begin fails++; $display("FAIL rd_gnt0: got %b expected 1", gnt0); end
        checks++; if (ram_we !== 1'b0)  begin fails++; $display("FAIL rd_ram_we: got %b expected 0", ram_we); end
        checks++; if (rvalid0 !== 1'b0) begin fails++; $display("FAIL wr_no_rvalid: got %b expected 0", rvalid0); end
        // port 0 writes 0x55 to address 7; read data from previous beat visible
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 7, 'h55, 1'b0, 1'b0, 1'b0, 0, 0); #1;
        checks++; if (rvalid0 !== 1'b1) begin fails++; $display("FAIL rd_rvalid0: got %b expected 1", rvalid0); end
        checks++; if (rdata0 !== 'hAA)  begin fails++; $display("FAIL rd_rdata0: got %h expected aa", rdata0); end
        checks++; if (ram_addr !== 7)   begin fails++; $display("FAIL wr7_ram_addr: got %h expected 7", ram_addr); end
        // port 1 reads address 7 the very next cycle
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 7, 0); #1;
        checks++; if (gnt1 !== 1'b1)    begin fails++; $display("FAIL x_gnt1: got %b expected 1", gnt1); end
        checks++; if (ram_addr !== 7)   begin fails++; $display("FAIL x_ram_addr: got %h expected 7", ram_addr); end
        checks++; if (rvalid0 !== 1'b0) begin fails++; $display("FAIL strobe_one_cycle: got %b expected 0", rvalid0); end
        checks++; if (rdata0 !== 'hAA)  begin fails++; $display("FAIL rdata0_hold: got %h expected aa", rdata0); end
        @(negedge clk); idle(); #1;
        checks++; if (rvalid1 !== 1'b1) begin fails++; $display("FAIL x_rvalid1: got %b expected 1", rvalid1); end
        checks++; if (rdata1 !== 'h55)  begin fails++; $display("FAIL x_rdata1: got %h expected 55", rdata1); end
    endtask

    task automatic test_round_robin();
        logic e0, rv0, rv1;
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 10, 'h1010, 1'b0, 1'b0, 1'b0, 0, 0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 11, 'h1111);
        // last winner is port 1, so the tie sequence starts with port 0
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(1'b1, 1'b0, 1'b0, 10, 0, 1'b1, 1'b0, 1'b0, 11, 0); #1;
            e0  = (i % 2 == 0);
            rv0 = (i > 0) && ((i - 1) % 2 == 0);
            rv1 = (i > 0) && ((i - 1) % 2 == 1);
            checks++; if (gnt0 !== e0)  begin fails++; $display("FAIL rr_gnt0[%0d]: got %b expected %b", i, gnt0, e0); end
            checks++; if (gnt1 !== !e0) begin fails++; $display("FAIL rr_gnt1[%0d]: got %b expected %b", i, gnt1, !e0); end
            checks++; if (gnt0 && gnt1) begin fails++; $display("FAIL rr_onehot[%0d]: got 11 expected at most one grant", i); end
            checks++; if (rvalid0 !== rv0) begin fails++; $display("FAIL rr_rvalid0[%0d]: got %b expected %b", i, rvalid0, rv0); end
            checks++; if (rvalid1 !== rv1) begin fails++; $display("FAIL rr_rvalid1[%0d]: got %b expected %b", i, rvalid1, rv1); end
            if (rv0) begin
                checks++; if (rdata0 !== 'h1010) begin fails++; $display("FAIL rr_rdata0[%0d]: got %h expected 1010", i, rdata0); end
            end
        end
        @(negedge clk); idle(); #1;
        checks++; if (rvalid1 !== 1'b1)  begin fails++; $display("FAIL rr_last_rvalid1: got %b expected 1", rvalid1); end
        checks++; if (rdata1 !== 'h1111) begin fails++; $display("FAIL rr_last_rdata1: got %h expected 1111", rdata1); end
        checks++; if (rvalid0 !== 1'b0)  begin fails++; $display("FAIL rr_last_rvalid0: got %b expected 0", rvalid0); end
    endtask

    task automatic test_burst();
        logic e1;
        // make port 0 the last winner, then idle so no owner is active
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 10, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        @(negedge clk); idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(1'b1, 1'b0, 1'b0, 10, 0, 1'b1, 1'b0, 1'b1, 11, 0); #1;
            e1 = (i < 4);
            checks++; if (gnt1 !== e1)  begin fails++; $display("FAIL burst_gnt1[%0d]: got %b expected %b", i, gnt1, e1); end
            checks++; if (gnt0 !== !e1) begin fails++; $display("FAIL burst_gnt0[%0d]: got %b expected %b", i, gnt0, !e1); end
        end
        @(negedge clk); idle(); #1;
        checks++; if (gnt0 || gnt1) begin fails++; $display("FAIL idle_no_grant: got %b%b expected 00", gnt1, gnt0); end
    endtask

    task automatic test_early_release();
        // port 1 locks, drops req after 2 beats, then locks again
        logic [7:0] exp1_tbl;
        logic       e1, r1;
        exp1_tbl = 8'b0111_1011;
        for (int i = 0; i < 8; i++) begin
            r1 = (i != 2);
            e1 = exp1_tbl[i];
            @(negedge clk); drive(1'b1, 1'b0, 1'b0, 10, 0, r1, 1'b0, 1'b1, 11, 0); #1;
            checks++; if (gnt1 !== e1)  begin fails++; $display("FAIL rel_gnt1[%0d]: got %b expected %b", i, gnt1, e1); end
            checks++; if (gnt0 !== !e1) begin fails++; $display("FAIL rel_gnt0[%0d]: got %b expected %b", i, gnt0, !e1); end
            checks++; if (ram_addr !== (e1 ? 11 : 10)) begin fails++; $display("FAIL rel_addr[%0d]: got %h expected %h", i, ram_addr, (e1 ? 11 : 10)); end
        end
        @(negedge clk); idle();
    endtask

    task automatic test_reset_mid();
        // port 0 read beat (last winner becomes 0), then reset next cycle
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 10, 0, 1'b0, 1'b0, 1'b0, 0, 0); #1;
        checks++; if (gnt0 !== 1'b1) begin fails++; $display("FAIL rst_beat_gnt0: got %b expected 1", gnt0); end
        @(negedge clk); idle(); reset = 1'b1; #1;
        checks++; if (rvalid0 !== 1'b1) begin fails++; $display("FAIL rst_pre_rvalid0: got %b expected 1", rvalid0); end
        @(negedge clk); reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 10, 0, 1'b1, 1'b0, 1'b0, 11, 0); #1;
        checks++; if (rvalid0 !== 1'b0) begin fails++; $display("FAIL rst_rvalid0: got %b expected 0", rvalid0); end
        checks++; if (rdata0 !== '0)    begin fails++; $display("FAIL rst_rdata0: got %h expected 0", rdata0); end
        checks++; if (gnt0 !== 1'b1)    begin fails++; $display("FAIL rst_tie_gnt0: got %b expected 1", gnt0); end
        checks++; if (gnt1 !== 1'b0)    begin fails++; $display("FAIL rst_tie_gnt1: got %b expected 0", gnt1); end
        @(negedge clk); idle(); #1;
        checks++; if (rvalid0 !== 1'b1)  begin fails++; $display("FAIL rst_after_rvalid0: got %b expected 1", rvalid0); end
        checks++; if (rdata0 !== 'h1010) begin fails++; $display("FAIL rst_after_rdata0: got %h expected 1010", rdata0); end
    endtask

`ifdef RAM_ARBITER_STATS_EN
    task automatic test_stats();
        @(negedge clk); idle(); stats_clr = 1'b1;
        @(negedge clk); stats_clr = 1'b0; #1;
        checks++; if (conflict_cnt !== 2'd0) begin fails++; $display("FAIL st_clr_conf: got %0d expected 0", conflict_cnt); end
        checks++; if (gnt_cnt0 !== 2'd0)     begin fails++; $display("FAIL st_clr_g0: got %0d expected 0", gnt_cnt0); end
        // last winner is port 0: grants go 1,0,1,0,1
        repeat (5) begin
            @(negedge clk); drive(1'b1, 1'b0, 1'b0, 10, 0, 1'b1, 1'b0, 1'b0, 11, 0);
        end
        @(negedge clk); idle(); #1;
        checks++; if (conflict_cnt !== 2'd3) begin fails++; $display("FAIL st_conf_sat: got %0d expected 3", conflict_cnt); end
        checks++; if (gnt_cnt1 !== 2'd3)     begin fails++; $display("FAIL st_g1: got %0d expected 3", gnt_cnt1); end
        checks++; if (gnt_cnt0 !== 2'd2)     begin fails++; $display("FAIL st_g0: got %0d expected 2", gnt_cnt0); end
        // clear coinciding with a conflict beat: clear wins
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 10, 0, 1'b1, 1'b0, 1'b0, 11, 0); stats_clr = 1'b1;
        @(negedge clk); idle(); stats_clr = 1'b0; #1;
        checks++; if (conflict_cnt !== 2'd0) begin fails++; $display("FAIL st_clrwin_conf: got %0d expected 0", conflict_cnt); end
        checks++; if (gnt_cnt0 !== 2'd0)     begin fails++; $display("FAIL st_clrwin_g0: got %0d expected 0", gnt_cnt0); end
        checks++; if (gnt_cnt1 !== 2'd0)     begin fails++; $display("FAIL st_clrwin_g1: got %0d expected 0", gnt_cnt1); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_burst();
        test_early_release();
        test_reset_mid();
`ifdef RAM_ARBITER_STATS_EN
        test_stats();
`endif
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
